// File: rtl/riscv_v_pkg.sv
// Shared vector-unit constants and the writeback pipeline packet type.
package riscv_v_pkg;

    localparam int unsigned VLEN       = 128;
    localparam int unsigned NUM_BYTES  = VLEN / 8;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_VREGS  = 32;

    typedef struct packed {
        logic [NUM_BYTES-1:0]  en;
        logic [REG_ADDR_W-1:0] addr;
        logic [VLEN-1:0]       data;
    } wb_pkt_t;

endpackage

// File: rtl/riscv_v_regfile.sv
// Vector register file: byte-enabled write port, two combinational read ports, v0 mask tap.
module riscv_v_regfile
    import riscv_v_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = VLEN,
    parameter int unsigned NUM_REGS   = NUM_VREGS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_stb,
    input  logic [NUM_BYTES-1:0]  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic [NUM_BYTES-1:0]  v0_mask
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] wr_mask;

    for (genvar b = 0; b < NUM_BYTES; b++) begin : g_mask
        assign wr_mask[b*8 +: 8] = {8{wr_en[b]}};
    end

    // Unenabled bytes are merged back from the old contents, so an all-zero enable is a no-op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r[REG_ADDR_W-1:0]] <= '0;
            end
        end else if (wr_stb) begin
            regs[wr_addr] <= (regs[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    // No write-through: same-cycle wb data reaches consumers via the bypass outputs.
    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
    assign v0_mask   = regs[0][NUM_BYTES-1:0];

endmodule

// File: rtl/riscv_v_rf_writeback.sv
// Execute -> mem -> wb pipeline registers feeding the vector register file, with bypass taps.
module riscv_v_rf_writeback
    import riscv_v_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = VLEN,
    parameter int unsigned NUM_REGS   = NUM_VREGS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH+NUM_BYTES-1:0] alu_result_exe,
    input  logic [REG_ADDR_W-1:0]           rf_wr_addr_exe,
    input  logic                            valid_exe,
    input  logic                            flush_exe,
    input  logic                            stall,
    input  logic [REG_ADDR_W-1:0]           rf_rd_addr_srca,
    input  logic [REG_ADDR_W-1:0]           rf_rd_addr_srcb,
    output logic [DATA_WIDTH-1:0]           srca,
    output logic [DATA_WIDTH-1:0]           srcb,
    output logic [NUM_BYTES-1:0]            mask_v0,
    output logic [NUM_BYTES-1:0]            rf_wr_en_mem,
    output logic [REG_ADDR_W-1:0]           rf_wr_addr_mem,
    output logic [DATA_WIDTH-1:0]           rf_wr_data_mem,
    output logic [NUM_BYTES-1:0]            rf_wr_en_wb,
    output logic [REG_ADDR_W-1:0]           rf_wr_addr_wb,
    output logic [DATA_WIDTH-1:0]           rf_wr_data_wb
);

    wb_pkt_t exe_pkt;
    wb_pkt_t mem_q;
    wb_pkt_t wb_q;

    // Invalid or flushed results travel down the pipe as bubbles (all-zero byte enables).
    always_comb begin
        exe_pkt      = '0;
        exe_pkt.data = alu_result_exe[DATA_WIDTH+NUM_BYTES-1:NUM_BYTES];
        exe_pkt.addr = rf_wr_addr_exe;
        exe_pkt.en   = (valid_exe && !flush_exe) ? alu_result_exe[NUM_BYTES-1:0] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!stall) begin
            mem_q <= exe_pkt;
            wb_q  <= mem_q;
        end
    end

    assign rf_wr_en_mem   = mem_q.en;
    assign rf_wr_addr_mem = mem_q.addr;
    assign rf_wr_data_mem = mem_q.data;
    assign rf_wr_en_wb    = wb_q.en;
    assign rf_wr_addr_wb  = wb_q.addr;
    assign rf_wr_data_wb  = wb_q.data;

    riscv_v_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst),
        .wr_stb    (!stall),
        .wr_en     (wb_q.en),
        .wr_addr   (wb_q.addr),
        .wr_data   (wb_q.data),
        .rd_addr_a (rf_rd_addr_srca),
        .rd_addr_b (rf_rd_addr_srcb),
        .rd_data_a (srca),
        .rd_data_b (srcb),
        .v0_mask   (mask_v0)
    );

endmodule

// File: tb/tb_riscv_v_rf_writeback.sv
// Directed self-checking bench for riscv_v_rf_writeback.
module tb_riscv_v_rf_writeback;

    logic         clk;
    logic         rst;
    logic [143:0] alu_result_exe;
    logic [4:0]   rf_wr_addr_exe;
    logic         valid_exe;
    logic         flush_exe;
    logic         stall;
    logic [4:0]   rf_rd_addr_srca;
    logic [4:0]   rf_rd_addr_srcb;
    logic [127:0] srca;
    logic [127:0] srcb;
    logic [15:0]  mask_v0;
    logic [15:0]  rf_wr_en_mem;
    logic [4:0]   rf_wr_addr_mem;
    logic [127:0] rf_wr_data_mem;
    logic [15:0]  rf_wr_en_wb;
    logic [4:0]   rf_wr_addr_wb;
    logic [127:0] rf_wr_data_wb;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_v_rf_writeback #(
        .DATA_WIDTH (128),
        .NUM_REGS   (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_result_exe  (alu_result_exe),
        .rf_wr_addr_exe  (rf_wr_addr_exe),
        .valid_exe       (valid_exe),
        .flush_exe       (flush_exe),
        .stall           (stall),
        .rf_rd_addr_srca (rf_rd_addr_srca),
        .rf_rd_addr_srcb (rf_rd_addr_srcb),
        .srca            (srca),
        .srcb            (srcb),
        .mask_v0         (mask_v0),
        .rf_wr_en_mem    (rf_wr_en_mem),
        .rf_wr_addr_mem  (rf_wr_addr_mem),
        .rf_wr_data_mem  (rf_wr_data_mem),
        .rf_wr_en_wb     (rf_wr_en_wb),
        .rf_wr_addr_wb   (rf_wr_addr_wb),
        .rf_wr_data_wb   (rf_wr_data_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input logic [4:0] a,
                         input logic [127:0] d, input logic [15:0] en);
        valid_exe      = v;
        flush_exe      = f;
        rf_wr_addr_exe = a;
        alu_result_exe = {d, en};
    endtask

    task automatic idle;
        valid_exe      = 1'b0;
        flush_exe      = 1'b0;
        rf_wr_addr_exe = '0;
        alu_result_exe = '0;
    endtask

    task automatic test_reset;
        rst = 1'b0; stall = 1'b0; idle();
        rf_rd_addr_srca = 5'd3; rf_rd_addr_srcb = 5'd31;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (rf_wr_en_mem !== 16'h0) begin n_fail++; $display("FAIL rst_mem_en: got %h exp 0", rf_wr_en_mem); end
        n_checks++; if (rf_wr_en_wb !== 16'h0) begin n_fail++; $display("FAIL rst_wb_en: got %h exp 0", rf_wr_en_wb); end
        n_checks++; if (rf_wr_data_mem !== 128'h0) begin n_fail++; $display("FAIL rst_mem_data: got %h exp 0", rf_wr_data_mem); end
        n_checks++; if (rf_wr_addr_wb !== 5'h0) begin n_fail++; $display("FAIL rst_wb_addr: got %h exp 0", rf_wr_addr_wb); end
        n_checks++; if (srca !== 128'h0) begin n_fail++; $display("FAIL rst_srca: got %h exp 0", srca); end
        n_checks++; if (srcb !== 128'h0) begin n_fail++; $display("FAIL rst_srcb: got %h exp 0", srcb); end
        n_checks++; if (mask_v0 !== 16'h0) begin n_fail++; $display("FAIL rst_mask_v0: got %h exp 0", mask_v0); end
        rst = 1'b1;
    endtask

    task automatic test_basic;
        logic [127:0] a5;
        a5 = {16{8'hA5}};
        drive(1'b1, 1'b0, 5'd3, a5, 16'hFFFF);
        tick();
        n_checks++; if (rf_wr_en_mem !== 16'hFFFF) begin n_fail++; $display("FAIL basic_mem_en: got %h exp ffff", rf_wr_en_mem); end
        n_checks++; if (rf_wr_addr_mem !== 5'd3) begin n_fail++; $display("FAIL basic_mem_addr: got %h exp 3", rf_wr_addr_mem); end
        n_checks++; if (rf_wr_data_mem !== a5) begin n_fail++; $display("FAIL basic_mem_data: got %h exp %h", rf_wr_data_mem, a5); end
        idle();
        tick();
        n_checks++; if (rf_wr_en_wb !== 16'hFFFF) begin n_fail++; $display("FAIL basic_wb_en: got %h exp ffff", rf_wr_en_wb); end
        n_checks++; if (rf_wr_addr_wb !== 5'd3) begin n_fail++; $display("FAIL basic_wb_addr: got %h exp 3", rf_wr_addr_wb); end
        n_checks++; if (rf_wr_data_wb !== a5) begin n_fail++; $display("FAIL basic_wb_data: got %h exp %h", rf_wr_data_wb, a5); end
        n_checks++; if (rf_wr_en_mem !== 16'h0) begin n_fail++; $display("FAIL basic_mem_bubble: got %h exp 0", rf_wr_en_mem); end
        rf_rd_addr_srca = 5'd3;
        #1;
        n_checks++; if (srca !== 128'h0) begin n_fail++; $display("FAIL basic_prewrite_read: got %h exp 0", srca); end
        tick();
        n_checks++; if (srca !== a5) begin n_fail++; $display("FAIL basic_rf_read: got %h exp %h", srca, a5); end
    endtask

    task automatic test_byte_enable;
        logic [127:0] exp_v5;
        exp_v5 = 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF;
        rf_rd_addr_srcb = 5'd5;
        drive(1'b1, 1'b0, 5'd5, {128{1'b1}}, 16'hFFFF);
        tick();
        drive(1'b1, 1'b0, 5'd5, 128'h0, 16'h00F0);
        tick();
        drive(1'b1, 1'b0, 5'd5, 128'h0, 16'h0000);
        tick();
        drive(1'b0, 1'b0, 5'd5, 128'h0, 16'hFFFF);
        tick();
        n_checks++; if (rf_wr_en_mem !== 16'h0) begin n_fail++; $display("FAIL be_invalid_mem_en: got %h exp 0", rf_wr_en_mem); end
        n_checks++; if (srcb !== exp_v5) begin n_fail++; $display("FAIL be_merge: got %h exp %h", srcb, exp_v5); end
        idle();
        tick();
        tick();
        n_checks++; if (srcb !== exp_v5) begin n_fail++; $display("FAIL be_bubble_hold: got %h exp %h", srcb, exp_v5); end
    endtask

    task automatic test_flush;
        rf_rd_addr_srca = 5'd7;
        drive(1'b1, 1'b0, 5'd7, {16{8'h11}}, 16'hFFFF);
        tick();
        drive(1'b1, 1'b1, 5'd7, {16{8'h22}}, 16'hFFFF);
        tick();
        n_checks++; if (rf_wr_en_mem !== 16'h0) begin n_fail++; $display("FAIL flush_mem_en: got %h exp 0", rf_wr_en_mem); end
        idle();
        tick();
        tick();
        n_checks++; if (srca !== {16{8'h11}}) begin n_fail++; $display("FAIL flush_v7: got %h exp %h", srca, {16{8'h11}}); end
    endtask

    task automatic test_stall;
        logic [127:0] x, y;
        x = {4{32'h1010_1010}};
        y = {4{32'h2020_2020}};
        drive(1'b1, 1'b0, 5'd10, x, 16'hFFFF);
        tick();
        drive(1'b1, 1'b0, 5'd11, y, 16'hFFFF);
        tick();
        stall = 1'b1;
        drive(1'b1, 1'b1, 5'd12, {4{32'h3030_3030}}, 16'hFFFF);
        rf_rd_addr_srca = 5'd10;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (rf_wr_en_mem !== 16'hFFFF) begin n_fail++; $display("FAIL stall_mem_en[%0d]: got %h exp ffff", c, rf_wr_en_mem); end
            n_checks++; if (rf_wr_addr_mem !== 5'd11) begin n_fail++; $display("FAIL stall_mem_addr[%0d]: got %h exp b", c, rf_wr_addr_mem); end
            n_checks++; if (rf_wr_data_wb !== x) begin n_fail++; $display("FAIL stall_wb_data[%0d]: got %h exp %h", c, rf_wr_data_wb, x); end
            n_checks++; if (srca !== 128'h0) begin n_fail++; $display("FAIL stall_rf_hold[%0d]: got %h exp 0", c, srca); end
            drive(1'b1, 1'b0, 5'd12, {4{32'h3030_3030}}, 16'hFFFF);
        end
        stall = 1'b0;
        idle();
        tick();
        n_checks++; if (srca !== x) begin n_fail++; $display("FAIL stall_release_v10: got %h exp %h", srca, x); end
        n_checks++; if (rf_wr_addr_wb !== 5'd11) begin n_fail++; $display("FAIL stall_release_wb_addr: got %h exp b", rf_wr_addr_wb); end
        n_checks++; if (rf_wr_en_mem !== 16'h0) begin n_fail++; $display("FAIL stall_release_mem_en: got %h exp 0", rf_wr_en_mem); end
        tick();
        rf_rd_addr_srca = 5'd11;
        rf_rd_addr_srcb = 5'd12;
        #1;
        n_checks++; if (srca !== y) begin n_fail++; $display("FAIL stall_release_v11: got %h exp %h", srca, y); end
        n_checks++; if (srcb !== 128'h0) begin n_fail++; $display("FAIL stall_ignored_v12: got %h exp 0", srcb); end
    endtask

    task automatic test_v0_and_reset;
        rf_rd_addr_srca = 5'd3;
        drive(1'b1, 1'b0, 5'd0, {112'h0, 16'h1234}, 16'hFFFF);
        tick();
        idle();
        tick();
        n_checks++; if (mask_v0 !== 16'h0) begin n_fail++; $display("FAIL v0_early: got %h exp 0", mask_v0); end
        tick();
        n_checks++; if (mask_v0 !== 16'h1234) begin n_fail++; $display("FAIL v0_mask: got %h exp 1234", mask_v0); end
        drive(1'b1, 1'b0, 5'd0, {112'h0, 16'h5678}, 16'hFFFF);
        tick();
        idle();
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (rf_wr_en_mem !== 16'h0) begin n_fail++; $display("FAIL midrst_mem_en: got %h exp 0", rf_wr_en_mem); end
        n_checks++; if (rf_wr_en_wb !== 16'h0) begin n_fail++; $display("FAIL midrst_wb_en: got %h exp 0", rf_wr_en_wb); end
        n_checks++; if (rf_wr_data_wb !== 128'h0) begin n_fail++; $display("FAIL midrst_wb_data: got %h exp 0", rf_wr_data_wb); end
        n_checks++; if (mask_v0 !== 16'h0) begin n_fail++; $display("FAIL midrst_mask: got %h exp 0", mask_v0); end
        n_checks++; if (srca !== 128'h0) begin n_fail++; $display("FAIL midrst_srca: got %h exp 0", srca); end
        #2;
        rst = 1'b1;
        repeat (3) tick();
        n_checks++; if (mask_v0 !== 16'h0) begin n_fail++; $display("FAIL midrst_write_lost: got %h exp 0", mask_v0); end
    endtask

    task automatic test_back_to_back;
        logic [127:0] a, b, merged;
        a      = 128'h0123456789ABCDEF_FEDCBA9876543210;
        b      = 128'hAAAABBBBCCCCDDDD_EEEEFFFF00001111;
        merged = 128'hAAAABBBBCCCCDDDD_FEDCBA9876543210;
        rf_rd_addr_srca = 5'd9;
        drive(1'b1, 1'b0, 5'd9, a, 16'h00FF);
        tick();
        drive(1'b1, 1'b0, 5'd9, b, 16'hFF00);
        tick();
        idle();
        tick();
        n_checks++; if (srca !== {64'h0, 64'hFEDCBA9876543210}) begin n_fail++; $display("FAIL b2b_first: got %h exp %h", srca, {64'h0, 64'hFEDCBA9876543210}); end
        tick();
        n_checks++; if (srca !== merged) begin n_fail++; $display("FAIL b2b_merged: got %h exp %h", srca, merged); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_enable();
        test_flush();
        test_stall();
        test_v0_and_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_v_rf_writeback.md
RISCV_V_RF_WRITEBACK -- requirements
Module: riscv_v_rf_writeback

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 128, vector register width in bits.
REQ-002 SHALL provide parameter NUM_REGS, default 32, number of vector registers.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL provide port alu_result_exe  input  144  execute result: [143:16] data, [15:0] per-byte write enables.
REQ-006 SHALL provide port rf_wr_addr_exe  input  5  destination vector register of the execute-stage result.
REQ-007 SHALL provide port valid_exe  input  1  execute-stage result is valid.
REQ-008 SHALL provide port flush_exe  input  1  kill the execute-stage result.
REQ-009 SHALL provide port stall  input  1  freeze the mem and wb stages.
REQ-010 SHALL provide ports rf_rd_addr_srca / rf_rd_addr_srcb  input  5 each  read addresses.
REQ-011 SHALL provide ports srca / srcb  output  128 each  read data.
REQ-012 SHALL provide port mask_v0  output  16  bits [15:0] of register v0.
REQ-013 SHALL provide ports rf_wr_en_mem  output  16, rf_wr_addr_mem  output  5, rf_wr_data_mem  output  128  mem-stage bypass source.
REQ-014 SHALL provide ports rf_wr_en_wb  output  16, rf_wr_addr_wb  output  5, rf_wr_data_wb  output  128  wb-stage bypass source.

Function
REQ-015 On a clock edge with stall=0, the mem stage SHALL capture data and address from exe; rf_wr_en_mem SHALL become alu_result_exe[15:0] if valid_exe=1 and flush_exe=0, else 16'h0.
REQ-016 On a clock edge with stall=0, the wb stage SHALL capture en/addr/data from the mem stage.
REQ-017 With stall=1, the mem and wb stages and the register file SHALL hold; exe inputs are ignored.
REQ-018 On a clock edge with stall=0, the register file SHALL write rf_wr_data_wb into register rf_wr_addr_wb for exactly those bytes i where rf_wr_en_wb[i]=1; other bytes keep their old value.
REQ-019 Latency: a result presented at exe in cycle N (no stall) SHALL appear on the mem outputs in N+1, on the wb outputs in N+2, and be readable from the register file in N+3.
REQ-020 Reads SHALL be combinational and return pre-write contents; a same-cycle wb write to the read address is not forwarded, since the bypass network covers it.
REQ-021 A write with rf_wr_en_wb=16'h0 SHALL leave the register file unchanged; an all-zero enable is a bubble.
REQ-022 Writes to register 0 SHALL be performed normally; v0 is a real register and mask_v0 reflects it.
REQ-023 flush_exe and stall both high SHALL leave state unchanged; the flush is honoured only on a non-stalled edge.

Reset
REQ-024 While rst=0, all mem/wb enables SHALL be 16'h0 and addresses/data 0, and every register-file entry SHALL be 0, so srca, srcb and mask_v0 read 0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight results with no partial register-file write; operation resumes on the first edge after rst returns to 1.

Structure
REQ-026 DATA_WIDTH (128), NUM_BYTES (16), register address width (5) and NUM_REGS (32) SHALL come from the shared riscv_v_pkg/riscv_pkg constants, with no local redefinition.
REQ-027 The storage array with byte-enabled write and two combinational read ports plus a v0 tap SHALL be a sub-module riscv_v_regfile; the pipeline registers live in the top module.

Verification
REQ-028 Reset, then valid write to v3, data 128'hA5..A5, enables 16'hFFFF -> mem outputs show it in cycle 1, wb in cycle 2, srca(addr 3) = A5..A5 in cycle 3.
REQ-029 Write v5 = all 1s, then write v5 data 0 with enables 16'h00F0 -> v5 reads FF..FF with bytes 4-7 equal to 00.
REQ-030 Valid write to v7 with flush_exe=1 -> rf_wr_en_mem = 0 and v7 is unchanged.
REQ-031 Hold stall=1 for 3 cycles with results in mem and wb -> outputs are frozen and the register file is unchanged; after release, writes complete in order.
REQ-032 Write v0[15:0] = 16'h1234 -> mask_v0 = 16'h1234 in cycle 3; assert rst with a write in flight -> all outputs 0 and the write is lost.
REQ-033 Back-to-back writes to v9 (bytes 0-7, then bytes 8-15) -> both merge and v9 holds the combined value.
